ibex_rvfi_trace_buf: RTL and testbench

- Hardware retirement-trace capture buffer. Sits beside ibex_top under `RVFI`, in parallel with the software tracer.
- Snoops the RVFI retirement stream and stores compact records in a parametrised circular buffer.
- Supports stop-on-full or wrap (overwrite-oldest) mode, plus an optional PC trigger with a post-trigger capture window.
- Drains records through a valid/ready stream port for a debug/MMIO reader.

---
 rtl/ibex_rvfi_trace_buf.sv | 123 ++++++++++++
 tb/tb_ibex_rvfi_trace_buf.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rvfi_trace_buf.sv
// RVFI retirement trace buffer: circular record store with stop/wrap full policy,
// PC trigger with a post-trigger capture window, and a FWFT valid/ready drain port.
module ibex_rvfi_trace_buf #(
  parameter int  Depth         = 16,
  parameter int  PostTrigDepth = 8,
  parameter int  DropCntW      = 16,
  localparam int RecW          = 103,
  localparam int PtrW          = $clog2(Depth),
  localparam int CntW          = PtrW + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rvfi_valid,
  input  logic                rvfi_trap,
  input  logic                rvfi_intr,
  input  logic [31:0]         rvfi_pc_rdata,
  input  logic [31:0]         rvfi_insn,
  input  logic [4:0]          rvfi_rd_addr,
  input  logic [31:0]         rvfi_rd_wdata,
  input  logic                trace_en_i,
  input  logic                wrap_mode_i,
  input  logic                trig_en_i,
  input  logic [31:0]         trig_pc_i,
  input  logic                clear_i,
  output logic                rec_valid_o,
  output logic [RecW-1:0]     rec_o,
  input  logic                rec_ready_i,
  output logic [CntW-1:0]     count_o,
  output logic [DropCntW-1:0] drop_cnt_o,
  output logic                triggered_o,
  output logic                frozen_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_POST, S_FROZEN} state_e;

  state_e              r_state, w_state_nxt;
  logic [RecW-1:0]     r_mem [Depth];
  logic [PtrW-1:0]     r_wptr, r_rptr, r_post;
  logic [CntW-1:0]     r_count;
  logic [DropCntW-1:0] r_drop;
  logic                r_trig;

  logic            w_cap, w_pop, w_full, w_hit, w_write, w_ovr, w_drop;
  logic [RecW-1:0] w_rec;

  assign w_rec   = {rvfi_trap, rvfi_intr, rvfi_rd_addr, rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata};
  assign w_cap   = rvfi_valid && ((r_state == S_RUN) || (r_state == S_POST));
  assign w_pop   = rec_valid_o && rec_ready_i;
  assign w_full  = (r_count == CntW'(Depth));
  assign w_hit   = w_cap && (r_state == S_RUN) && trig_en_i && (rvfi_pc_rdata == trig_pc_i);
  // A pop in the same cycle frees the slot, so only an un-popped full capture is lost.
  assign w_drop  = w_cap && w_full && !w_pop;
  assign w_ovr   = w_drop && wrap_mode_i;
  assign w_write = w_cap && (!w_drop || wrap_mode_i);

  assign rec_o       = r_mem[r_rptr];
  assign count_o     = r_count;
  assign drop_cnt_o  = r_drop;
  assign triggered_o = r_trig;

  always_ff @(posedge clk_i) begin
    if (w_write && !clear_i) r_mem[r_wptr] <= w_rec;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drop  <= '0;
      r_trig  <= 1'b0;
      r_post  <= '0;
    end else if (clear_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drop  <= '0;
      r_trig  <= 1'b0;
      r_post  <= '0;
    end else begin
      if (w_write) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop || w_ovr) r_rptr <= r_rptr + PtrW'(1);
      if (w_write && !w_pop && !w_ovr) r_count <= r_count + CntW'(1);
      else if (w_pop && !w_write) r_count <= r_count - CntW'(1);
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + DropCntW'(1);
      if (w_hit) r_trig <= 1'b1;
      if (((r_state == S_RUN) || (r_state == S_POST)) && !trace_en_i) r_post <= '0;
      else if (w_hit) r_post <= PtrW'(PostTrigDepth);
      else if ((r_state == S_POST) && w_cap) r_post <= r_post - PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear_i) begin
      w_state_nxt = trace_en_i ? S_RUN : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (trace_en_i) w_state_nxt = S_RUN;
        S_RUN: begin
          if (!trace_en_i) w_state_nxt = S_IDLE;
          else if (w_hit)  w_state_nxt = (PostTrigDepth == 0) ? S_FROZEN : S_POST;
        end
        S_POST: begin
          if (!trace_en_i)                          w_state_nxt = S_IDLE;
          else if (w_cap && (r_post == PtrW'(1)))   w_state_nxt = S_FROZEN;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    rec_valid_o = (r_count != '0);
    frozen_o    = (r_state == S_FROZEN);
  end

endmodule

// File: tb/tb_ibex_rvfi_trace_buf.sv
// Bench for ibex_rvfi_trace_buf: two instances (Depth 8/post 2/4-bit drop, Depth 4/post 0)
// share stimulus; a queue-based model per instance feeds a negedge monitor.
module tb_ibex_rvfi_trace_buf;
  typedef logic [102:0] rec_t;
  localparam int M_IDLE = 0, M_RUN = 1, M_POST = 2, M_FRZ = 3;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        valid = 1'b0, trap = 1'b0, intr = 1'b0, en = 1'b0, wrap = 1'b0;
  logic        trig_en = 1'b0, clr = 1'b0;
  logic [4:0]  rd = '0;
  logic [31:0] pc = '0, insn = '0, wdata = '0, trig_pc = '0;
  logic        rdy [2];

  logic        a_rv, a_trig, a_frz, b_rv, b_trig, b_frz;
  rec_t        a_rec, b_rec;
  logic [3:0]  a_cnt, a_drop;
  logic [2:0]  b_cnt;
  logic [15:0] b_drop;

  int n_tests = 0, n_fail = 0;

  rec_t mq [2][$];
  int   m_st [2], m_post [2], m_drop [2], m_trig [2];
  int   m_depth [2] = '{8, 4};
  int   m_ptd   [2] = '{2, 0};
  int   m_dmax  [2] = '{15, 65535};

  always #5 clk = ~clk;

  ibex_rvfi_trace_buf #(.Depth(8), .PostTrigDepth(2), .DropCntW(4)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .rvfi_valid(valid), .rvfi_trap(trap), .rvfi_intr(intr),
    .rvfi_pc_rdata(pc), .rvfi_insn(insn), .rvfi_rd_addr(rd), .rvfi_rd_wdata(wdata),
    .trace_en_i(en), .wrap_mode_i(wrap), .trig_en_i(trig_en), .trig_pc_i(trig_pc),
    .clear_i(clr), .rec_valid_o(a_rv), .rec_o(a_rec), .rec_ready_i(rdy[0]),
    .count_o(a_cnt), .drop_cnt_o(a_drop), .triggered_o(a_trig), .frozen_o(a_frz));

  ibex_rvfi_trace_buf #(.Depth(4), .PostTrigDepth(0), .DropCntW(16)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .rvfi_valid(valid), .rvfi_trap(trap), .rvfi_intr(intr),
    .rvfi_pc_rdata(pc), .rvfi_insn(insn), .rvfi_rd_addr(rd), .rvfi_rd_wdata(wdata),
    .trace_en_i(en), .wrap_mode_i(wrap), .trig_en_i(trig_en), .trig_pc_i(trig_pc),
    .clear_i(clr), .rec_valid_o(b_rv), .rec_o(b_rec), .rec_ready_i(rdy[1]),
    .count_o(b_cnt), .drop_cnt_o(b_drop), .triggered_o(b_trig), .frozen_o(b_frz));

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      m_st[k] = M_IDLE; m_post[k] = 0; m_drop[k] = 0; m_trig[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    rec_t r;
    bit   cap, hit;
    r = {trap, intr, rd, pc, insn, wdata};
    if (clr) begin
      mq[k].delete();
      m_drop[k] = 0; m_trig[k] = 0; m_post[k] = 0;
      m_st[k] = en ? M_RUN : M_IDLE;
      return;
    end
    if (mq[k].size() > 0 && rdy[k]) void'(mq[k].pop_front());
    cap = valid && (m_st[k] == M_RUN || m_st[k] == M_POST);
    if (cap) begin
      if (mq[k].size() < m_depth[k]) mq[k].push_back(r);
      else begin
        if (m_drop[k] < m_dmax[k]) m_drop[k]++;
        if (wrap) begin
          void'(mq[k].pop_front());
          mq[k].push_back(r);
        end
      end
    end
    hit = cap && trig_en && (pc == trig_pc) && (m_st[k] == M_RUN);
    if (hit) m_trig[k] = 1;
    case (m_st[k])
      M_IDLE: if (en) m_st[k] = M_RUN;
      M_RUN: begin
        if (!en) begin m_st[k] = M_IDLE; m_post[k] = 0; end
        else if (hit) begin
          m_post[k] = m_ptd[k];
          m_st[k]   = (m_ptd[k] == 0) ? M_FRZ : M_POST;
        end
      end
      M_POST: begin
        if (!en) begin m_st[k] = M_IDLE; m_post[k] = 0; end
        else if (cap) begin
          m_post[k]--;
          if (m_post[k] == 0) m_st[k] = M_FRZ;
        end
      end
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k);
  end

  // Monitor: compare every observable output against the model between edges.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic v;
      rec_t h;
      v = (k == 0) ? a_rv : b_rv;
      h = (k == 0) ? a_rec : b_rec;
      chk($sformatf("mon_valid[%0d]", k), longint'(v), longint'(mq[k].size() != 0));
      chk($sformatf("mon_count[%0d]", k), (k == 0) ? longint'(a_cnt) : longint'(b_cnt), longint'(mq[k].size()));
      chk($sformatf("mon_drop[%0d]", k), (k == 0) ? longint'(a_drop) : longint'(b_drop), longint'(m_drop[k]));
      chk($sformatf("mon_trig[%0d]", k), (k == 0) ? longint'(a_trig) : longint'(b_trig), longint'(m_trig[k]));
      chk($sformatf("mon_frozen[%0d]", k), (k == 0) ? longint'(a_frz) : longint'(b_frz), longint'(m_st[k] == M_FRZ));
      if (v && mq[k].size() != 0) begin
        n_tests++;
        if (h !== mq[k][0]) begin
          n_fail++;
          $display("FAIL mon_head[%0d]: got %h expected %h at %0t", k, h, mq[k][0], $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] p);
    valid = 1'b1; pc = p;
    insn = $urandom; wdata = $urandom; rd = 5'($urandom);
    trap = 1'($urandom); intr = 1'($urandom);
    tick();
    valid = 1'b0;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic drain();
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    repeat (12) tick();
    rdy[0] = 1'b0; rdy[1] = 1'b0;
    chk("drain_empty_a", longint'(a_rv), 0);
    chk("drain_empty_b", longint'(b_rv), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    rdy[0] = 1'b0; rdy[1] = 1'b0;
    repeat (2) tick();
    chk("rst_count_a", longint'(a_cnt), 0);
    chk("rst_count_b", longint'(b_cnt), 0);
    chk("rst_valid_b", longint'(b_rv), 0);
    chk("rst_frozen_a", longint'(a_frz), 0);
    rst_n = 1'b1; en = 1'b1;
    tick();

    // Stop-on-full: the oldest four survive in B.
    for (int i = 0; i < 6; i++) retire(32'h100 + 32'(4 * i));
    chk("nowrap_count_b", longint'(b_cnt), 4);
    chk("nowrap_drop_b", longint'(b_drop), 2);
    chk("nowrap_count_a", longint'(a_cnt), 6);
    chk("nowrap_head_b", longint'(b_rec[95:64]), 32'h100);
    drain();

    // Wrap: the newest four survive in B.
    wrap = 1'b1;
    do_clear();
    for (int i = 0; i < 6; i++) retire(32'h100 + 32'(4 * i));
    chk("wrap_count_b", longint'(b_cnt), 4);
    chk("wrap_drop_b", longint'(b_drop), 2);
    chk("wrap_head_b", longint'(b_rec[95:64]), 32'h108);
    drain();

    // Full with a simultaneous pop: no drop, 0x200 lands at the tail.
    wrap = 1'b0;
    do_clear();
    for (int i = 0; i < 4; i++) retire(32'h100 + 32'(4 * i));
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    retire(32'h200);
    rdy[0] = 1'b0; rdy[1] = 1'b0;
    chk("fullpop_count_b", longint'(b_cnt), 4);
    chk("fullpop_drop_b", longint'(b_drop), 0);
    drain();

    // Trigger: A has a 2-record window, B freezes on the trigger record.
    do_clear();
    trig_en = 1'b1; trig_pc = 32'h300;
    retire(32'h2F8); retire(32'h2FC); retire(32'h300);
    chk("trig_triggered_a", longint'(a_trig), 1);
    chk("trig_frozen_a_early", longint'(a_frz), 0);
    chk("trig_frozen_b", longint'(b_frz), 1);
    retire(32'h304); retire(32'h308);
    chk("trig_frozen_a", longint'(a_frz), 1);
    retire(32'h30C);
    chk("trig_count_a", longint'(a_cnt), 5);
    chk("trig_count_b", longint'(b_cnt), 3);
    do_clear();
    chk("clr_count_b", longint'(b_cnt), 0);
    chk("clr_frozen_b", longint'(b_frz), 0);
    chk("clr_trig_b", longint'(b_trig), 0);
    retire(32'h500);
    chk("clr_run_count_b", longint'(b_cnt), 1);
    drain();

    // Drop counter saturation on the 4-bit instance.
    trig_en = 1'b0; wrap = 1'b1;
    do_clear();
    for (int i = 0; i < 30; i++) retire(32'h1000 + 32'(4 * i));
    chk("sat_drop_a", longint'(a_drop), 15);
    chk("sat_drop_b", longint'(b_drop), 26);
    chk("sat_count_a", longint'(a_cnt), 8);
    drain();

    // Asynchronous reset while A is in its post-trigger window.
    trig_en = 1'b1; wrap = 1'b0;
    do_clear();
    retire(32'h2F8); retire(32'h2FC); retire(32'h300);
    chk("prerst_count_a", longint'(a_cnt), 3);
    rst_n = 1'b0;
    #1;
    chk("arst_count_a", longint'(a_cnt), 0);
    chk("arst_valid_a", longint'(a_rv), 0);
    chk("arst_trig_a", longint'(a_trig), 0);
    chk("arst_frozen_b", longint'(b_frz), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    retire(32'h400);
    chk("postrst_valid_a", longint'(a_rv), 1);
    chk("postrst_head_a", longint'(a_rec[95:64]), 32'h400);

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      valid   = ($urandom % 3) != 0;
      pc      = (($urandom % 5) == 0) ? 32'h300 : 32'h1000 + 32'(4 * ($urandom % 64));
      insn    = $urandom; wdata = $urandom; rd = 5'($urandom);
      trap    = 1'($urandom); intr = 1'($urandom);
      trig_en = ($urandom % 4) == 0;
      en      = ($urandom % 32) != 0;
      clr     = ($urandom % 64) == 0;
      if ((c % 16) == 0) wrap = 1'($urandom);
      rdy[0]  = 1'($urandom);
      rdy[1]  = 1'($urandom);
      tick();
    end
    valid = 1'b0; clr = 1'b0; en = 1'b1;
    drain();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
